word_dispatch: RTL and testbench
================================

WORD_DISPATCH -- requirements
Module: word_dispatch

Interface
REQ-001 SHALL have parameter CHAR_W, 8, bits per letter code.
REQ-002 SHALL have parameter MAX_LEN, 15, max letters per word (word width CHAR_W*MAX_LEN = 120).
REQ-003 SHALL have parameter DICT_SIZE, 500, dictionary entries in the match mask.
REQ-004 SHALL have port i_word_dispatch_clk  in  1  clock; single clock domain.
REQ-005 SHALL have port i_word_dispatch_rst_n  in  1  asynchronous active-low reset.
REQ-006 SHALL have ports i_word_dispatch_char_valid  in  1 / i_word_dispatch_char  in  8 / o_word_dispatch_char_ready  out  1: letter stream.
REQ-007 SHALL have port i_word_dispatch_eow  in  1  end-of-word pulse.
REQ-008 SHALL have port i_word_dispatch_clear  in  1  discard partial word.
REQ-009 SHALL have ports o_word_dispatch_sim_start  out  1 / o_word_dispatch_sim_word  out  120: request to similarity engine.
REQ-010 SHALL have ports i_word_dispatch_sim_finish  in  1 / i_word_dispatch_sim_match  in  500: engine result, bit k = dictionary entry k matches.
REQ-011 SHALL have ports o_word_dispatch_idx_valid  out  1 / o_word_dispatch_idx  out  9 / i_word_dispatch_idx_ready  in  1: matched-index stream.
REQ-012 SHALL have ports o_word_dispatch_done  out  1 (one-cycle pulse) / o_word_dispatch_count  out  9 (matches reported).

Function
REQ-013 SHALL implement FSM COLLECT -> START -> WAIT -> SCAN -> DONE -> COLLECT.
REQ-014 COLLECT: char_ready = (len < MAX_LEN); on valid&ready word <= {word[111:0], char}, len++ (newest letter at [7:0], unused upper bytes zero).
REQ-015 COLLECT: eow with len > 0 -> START; eow with len == 0 ignored; char and eow in same cycle: char appended first, then transition.
REQ-016 COLLECT: clear zeroes word and len; clear wins over char in same cycle; clear ignored outside COLLECT.
REQ-017 char_ready SHALL be 0 in all states except COLLECT.
REQ-018 START: sim_start high exactly one cycle, then WAIT; sim_word held stable from START through last WAIT cycle.
REQ-019 WAIT: on sim_finish sampled high at edge N, capture sim_match into internal mask, go SCAN; sim_finish ignored in every other state.
REQ-020 SCAN: pointer p from 0 to DICT_SIZE-1; idx_valid = mask[p], idx = p; p advances when !mask[p] or idx_ready; first bit k set gives idx_valid in cycle N+1+k.
REQ-021 idx and idx_valid SHALL hold stable while idx_valid & !idx_ready; no index skipped or repeated.
REQ-022 count SHALL increment on each idx handshake, clear on START, hold after DONE until next START.
REQ-023 After p = DICT_SIZE-1 retires -> DONE: done high one cycle (cycle N+1+DICT_SIZE with no backpressure), word and len cleared, -> COLLECT.

Reset
REQ-024 Reset SHALL asynchronously force COLLECT, word, len, mask, p, count = 0 and all outputs 0 except char_ready = 1 after reset release.
REQ-025 Reset mid-operation SHALL abort without emitting done or idx_valid; a later stray sim_finish SHALL be ignored.

Configuration
REQ-026 Macro WORD_DISPATCH_FIRST_ONLY_EN defined: SCAN ends after first idx handshake -> DONE next cycle, count <= 1; undefined: all matches reported per REQ-020..023.

Structure
REQ-027 Package word_dispatch_pkg SHALL hold CHAR_W, MAX_LEN, WORD_W, DICT_SIZE, IDX_W = 9 and the FSM state enum.
REQ-028 Sub-module match_scanner SHALL contain mask register, pointer, valid/ready logic and count.

Verification
REQ-029 Chars 0x12,0x0F,0x0F,0x0D then eow -> sim_word = 120'h120F0F0D, sim_start one-cycle pulse.
REQ-030 Finish at edge N, mask bits 3,42,499, ready = 1 -> idx 3,42,499 in cycles N+4,N+43,N+500; done at N+501; count = 3.
REQ-031 Same mask, ready low 5 cycles while idx = 42 -> idx 42 held 6 cycles, then 499; count = 3.
REQ-032 16 chars offered -> 16th stalls (char_ready = 0), word holds first 15; eow with len 0 -> no sim_start.
REQ-033 All-zero mask -> no idx_valid, done at N+501, count = 0.
REQ-034 Reset asserted in WAIT, then sim_finish -> outputs stay 0, no idx_valid, no done.

Source files
------------

// File: rtl/word_dispatch_pkg.sv
// word_dispatch_pkg: shared sizes and FSM encoding
// for the word dispatcher and its match scanner.
package word_dispatch_pkg;

  localparam int CHAR_W    = 8;
  localparam int MAX_LEN   = 15;
  localparam int WORD_W    = CHAR_W * MAX_LEN;
  localparam int DICT_SIZE = 500;
  localparam int IDX_W     = 9;

  typedef enum logic [2:0] {
    ST_COLLECT,
    ST_START,
    ST_WAIT,
    ST_SCAN,
    ST_DONE
  } state_e;

endpackage

// File: rtl/word_dispatch_match_scanner.sv
// match_scanner: walks the captured match mask and streams
// matched indices over valid/ready. WORD_DISPATCH_FIRST_ONLY_EN stops at first hit.
module match_scanner
  import word_dispatch_pkg::*;
#(
  parameter int NUM = DICT_SIZE,
  parameter int IW  = IDX_W
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  input  logic           load_i,
  input  logic [NUM-1:0] match_i,
  input  logic           scan_i,
  input  logic           clr_cnt_i,
  input  logic           ready_i,
  output logic           valid_o,
  output logic [IW-1:0]  idx_o,
  output logic [IW-1:0]  count_o,
  output logic           end_o
);

  logic [NUM-1:0] mask_q, mask_d;
  logic [IW-1:0]  p_q, p_d;
  logic [IW-1:0]  cnt_q, cnt_d;
  logic           hit;
  logic           hs;
  logic           retire;
  logic           last;

  assign hit    = scan_i & mask_q[p_q];
  assign hs     = hit & ready_i;
  assign retire = scan_i & (~mask_q[p_q] | ready_i);
  assign last   = (p_q == IW'(NUM - 1));

`ifdef WORD_DISPATCH_FIRST_ONLY_EN
  assign end_o = hs | (retire & last);
`else
  assign end_o = retire & last;
`endif

  assign valid_o = hit;
  assign idx_o   = p_q;
  assign count_o = cnt_q;

  always_comb begin
    mask_d = mask_q;
    p_d    = p_q;
    cnt_d  = cnt_q;
    if (load_i) begin
      mask_d = match_i;
      p_d    = '0;
    end else if (retire && !last) begin
      p_d = p_q + 1'b1;
    end
    if (clr_cnt_i) begin
      cnt_d = '0;
    end else if (hs) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mask_q <= '0;
      p_q    <= '0;
      cnt_q  <= '0;
    end else begin
      mask_q <= mask_d;
      p_q    <= p_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/word_dispatch.sv
// word_dispatch: collects letters into a word, hands it to the similarity
// engine, then streams matched indices. Option: WORD_DISPATCH_FIRST_ONLY_EN.
module word_dispatch #(
  parameter int CHAR_W    = 8,
  parameter int MAX_LEN   = 15,
  parameter int DICT_SIZE = 500
) (
  input  logic                         i_word_dispatch_clk,
  input  logic                         i_word_dispatch_rst_n,
  input  logic                         i_word_dispatch_char_valid,
  input  logic [CHAR_W-1:0]            i_word_dispatch_char,
  output logic                         o_word_dispatch_char_ready,
  input  logic                         i_word_dispatch_eow,
  input  logic                         i_word_dispatch_clear,
  output logic                         o_word_dispatch_sim_start,
  output logic [CHAR_W*MAX_LEN-1:0]    o_word_dispatch_sim_word,
  input  logic                         i_word_dispatch_sim_finish,
  input  logic [DICT_SIZE-1:0]         i_word_dispatch_sim_match,
  output logic                         o_word_dispatch_idx_valid,
  output logic [$clog2(DICT_SIZE)-1:0] o_word_dispatch_idx,
  input  logic                         i_word_dispatch_idx_ready,
  output logic                         o_word_dispatch_done,
  output logic [$clog2(DICT_SIZE)-1:0] o_word_dispatch_count
);

  import word_dispatch_pkg::*;

  localparam int WW = CHAR_W * MAX_LEN;
  localparam int LW = $clog2(MAX_LEN + 1);
  localparam int IW = $clog2(DICT_SIZE);

  state_e        state_q, state_d;
  logic [WW-1:0] word_q, word_d;
  logic [LW-1:0] len_q, len_d;
  logic          ready;
  logic          load;
  logic          clr_cnt;
  logic          scan;
  logic          scan_end;

  assign scan = (state_q == ST_SCAN);

  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    len_d   = len_q;
    ready   = 1'b0;
    load    = 1'b0;
    clr_cnt = 1'b0;
    o_word_dispatch_sim_start = 1'b0;
    o_word_dispatch_done      = 1'b0;
    unique case (state_q)
      ST_COLLECT: begin
        ready = (len_q < LW'(MAX_LEN));
        if (i_word_dispatch_clear) begin
          word_d = '0;
          len_d  = '0;
        end else if (i_word_dispatch_char_valid && ready) begin
          word_d = {word_q[WW-CHAR_W-1:0], i_word_dispatch_char};
          len_d  = len_q + 1'b1;
        end
        // a letter arriving with eow counts toward the word
        if (i_word_dispatch_eow && (len_d != '0)) begin
          state_d = ST_START;
        end
      end
      ST_START: begin
        o_word_dispatch_sim_start = 1'b1;
        clr_cnt = 1'b1;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (i_word_dispatch_sim_finish) begin
          load    = 1'b1;
          state_d = ST_SCAN;
        end
      end
      ST_SCAN: begin
        if (scan_end) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        o_word_dispatch_done = 1'b1;
        word_d  = '0;
        len_d   = '0;
        state_d = ST_COLLECT;
      end
      default: begin
        state_d = ST_COLLECT;
      end
    endcase
  end

  always_ff @(posedge i_word_dispatch_clk or negedge i_word_dispatch_rst_n) begin
    if (!i_word_dispatch_rst_n) begin
      state_q <= ST_COLLECT;
      word_q  <= '0;
      len_q   <= '0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      len_q   <= len_d;
    end
  end

  assign o_word_dispatch_char_ready = ready;
  assign o_word_dispatch_sim_word   = word_q;

  match_scanner #(
    .NUM (DICT_SIZE),
    .IW  (IW)
  ) u_scan (
    .clk_i     (i_word_dispatch_clk),
    .rst_ni    (i_word_dispatch_rst_n),
    .load_i    (load),
    .match_i   (i_word_dispatch_sim_match),
    .scan_i    (scan),
    .clr_cnt_i (clr_cnt),
    .ready_i   (i_word_dispatch_idx_ready),
    .valid_o   (o_word_dispatch_idx_valid),
    .idx_o     (o_word_dispatch_idx),
    .count_o   (o_word_dispatch_count),
    .end_o     (scan_end)
  );

endmodule

// File: tb/tb_word_dispatch.sv
// tb_word_dispatch: directed stimulus, per-cycle comparison against
// a queue-based model, plus literal timing/value expectations.
module tb_word_dispatch;

  localparam int DS = 500;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          cvalid = 1'b0;
  logic [7:0]    ch = '0;
  logic          cready;
  logic          eow = 1'b0;
  logic          clear = 1'b0;
  logic          start;
  logic [119:0]  word;
  logic          finish = 1'b0;
  logic [DS-1:0] match = '0;
  logic          idxv;
  logic [8:0]    idx;
  logic          iready = 1'b1;
  logic          done;
  logic [8:0]    count;

  always #5 clk = ~clk;

  word_dispatch dut (
    .i_word_dispatch_clk        (clk),
    .i_word_dispatch_rst_n      (rst_n),
    .i_word_dispatch_char_valid (cvalid),
    .i_word_dispatch_char       (ch),
    .o_word_dispatch_char_ready (cready),
    .i_word_dispatch_eow        (eow),
    .i_word_dispatch_clear      (clear),
    .o_word_dispatch_sim_start  (start),
    .o_word_dispatch_sim_word   (word),
    .i_word_dispatch_sim_finish (finish),
    .i_word_dispatch_sim_match  (match),
    .o_word_dispatch_idx_valid  (idxv),
    .o_word_dispatch_idx        (idx),
    .i_word_dispatch_idx_ready  (iready),
    .o_word_dispatch_done       (done),
    .o_word_dispatch_count      (count)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // model: phase, letters so far, pending matched indices
  typedef enum int {M_COL, M_START, M_WAIT, M_SCAN, M_DONE} mph_e;
  mph_e         ph = M_COL;
  int           mlen = 0;
  logic [119:0] mword = '0;
  int           mq[$];
  int           rel = 0;
  int           stalls = 0;
  int           mcnt = 0;
  logic         exp_v;
  int           exp_idx;
  logic         fin;

  int hs_rel[$];
  int hs_idx[$];
  int done_rel = -1;
  int hold42 = 0;
  int n_start = 0;
  int n_idxv = 0;
  int n_done = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      ph = M_COL; mlen = 0; mword = '0; mq.delete();
      mcnt = 0; rel = 0; stalls = 0;
    end
    if (ph == M_SCAN || ph == M_DONE) rel++;
    exp_v = 1'b0;
    exp_idx = 0;
    if (ph == M_SCAN && mq.size() > 0 && rel == 1 + mq[0] + stalls) begin
      exp_v = 1'b1;
      exp_idx = mq[0];
    end
    chk("char_ready", 128'(cready), 128'(ph == M_COL && mlen < 15));
    chk("sim_start", 128'(start), 128'(ph == M_START));
    chk("sim_word", 128'(word), 128'(mword));
    chk("idx_valid", 128'(idxv), 128'(exp_v));
    if (exp_v) chk("idx", 128'(idx), 128'(exp_idx));
    chk("done", 128'(done), 128'(ph == M_DONE));
    chk("count", 128'(count), 128'(mcnt));
    if (start) n_start++;
    if (idxv) n_idxv++;
    if (done) begin n_done++; done_rel = rel; end
    if (idxv && idx == 9'd42) hold42++;
    if (idxv && iready) begin
      hs_rel.push_back(rel);
      hs_idx.push_back(int'(idx));
    end
    if (rst_n) begin
      case (ph)
        M_COL: begin
          if (clear) begin
            mword = '0; mlen = 0;
          end else if (cvalid && mlen < 15) begin
            mword = mword * 256 + 120'(ch);
            mlen++;
          end
          if (eow && mlen > 0) ph = M_START;
        end
        M_START: begin mcnt = 0; ph = M_WAIT; end
        M_WAIT: begin
          if (finish) begin
            mq.delete();
            for (int k = 0; k < DS; k++) if (match[k]) mq.push_back(k);
            rel = 0; stalls = 0; ph = M_SCAN;
          end
        end
        M_SCAN: begin
          if (exp_v && !iready) stalls++;
          if (exp_v && iready) begin void'(mq.pop_front()); mcnt++; end
          fin = (rel == DS + stalls);
`ifdef WORD_DISPATCH_FIRST_ONLY_EN
          if (exp_v && iready) fin = 1'b1;
`endif
          if (fin) ph = M_DONE;
        end
        default: begin mword = '0; mlen = 0; ph = M_COL; end
      endcase
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic send(input logic [7:0] c);
    cvalid = 1'b1; ch = c; tick(); cvalid = 1'b0;
  endtask

  task automatic end_word();
    eow = 1'b1; tick(); eow = 1'b0;
  endtask

  task automatic run_scan(input logic [DS-1:0] m, input int stall);
    int  left;
    logic seen;
    left = stall;
    seen = 1'b0;
    hs_rel.delete(); hs_idx.delete(); done_rel = -1; hold42 = 0;
    match = m; finish = 1'b1; tick(); finish = 1'b0; match = '0;
    for (int c = 0; c < 1200 && !seen; c++) begin
      if (idxv && idx == 9'd42 && left > 0) begin
        iready = 1'b0; left--;
      end else begin
        iready = 1'b1;
      end
      if (done) seen = 1'b1;
      tick();
    end
    iready = 1'b1;
    chk("scan_timeout", 128'(seen), 128'(1));
  endtask

  task automatic chk_hs(input string nm, input int ei[3], input int er[3]);
    chk({nm, "_n"}, 128'(hs_idx.size()), 128'(3));
    for (int i = 0; i < 3; i++) begin
      chk({nm, "_idx"}, 128'(i < hs_idx.size() ? hs_idx[i] : -1), 128'(ei[i]));
      chk({nm, "_cyc"}, 128'(i < hs_rel.size() ? hs_rel[i] : -1), 128'(er[i]));
    end
  endtask

  logic [DS-1:0] m3;
  int ei[3];
  int er[3];
  int b_idxv;
  int b_done;

  initial begin
    m3 = '0;
    m3[3] = 1'b1; m3[42] = 1'b1; m3[499] = 1'b1;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk); #1;
    chk("rst_char_ready", 128'(cready), 128'(1));
    chk("rst_idx_valid", 128'(idxv), 128'(0));
    chk("rst_count", 128'(count), 128'(0));
    chk("rst_word", 128'(word), 128'(0));
    chk("rst_done", 128'(done), 128'(0));
    tick();

    end_word();
    repeat (3) tick();
    chk("eow_empty_no_start", 128'(n_start), 128'(0));

    for (int i = 1; i <= 16; i++) begin
      cvalid = 1'b1; ch = 8'(i); tick();
    end
    cvalid = 1'b0;
    chk("full_ready_low", 128'(cready), 128'(0));
    chk("full_word", 128'(word), 128'(120'h0102030405060708090A0B0C0D0E0F));
    clear = 1'b1; tick(); clear = 1'b0;
    chk("clear_word", 128'(word), 128'(0));
    chk("clear_ready", 128'(cready), 128'(1));

    send(8'h12); send(8'h0F); send(8'h0F); send(8'h0D);
    end_word();
    chk("start_pulse", 128'(start), 128'(1));
    chk("start_word", 128'(word), 128'(120'h120F0F0D));
    tick();
    chk("start_one_cycle", 128'(start), 128'(0));
    repeat (3) tick();
    chk("wait_word_stable", 128'(word), 128'(120'h120F0F0D));
    run_scan(m3, 0);
    ei = '{3, 42, 499}; er = '{4, 43, 500};
    chk_hs("t1", ei, er);
    chk("t1_done_cyc", 128'(done_rel), 128'(501));
    chk("t1_count", 128'(count), 128'(3));
    chk("t1_word_cleared", 128'(word), 128'(0));

    send(8'h41); end_word(); repeat (2) tick();
    run_scan(m3, 5);
    er = '{4, 48, 505};
    chk_hs("t2", ei, er);
    chk("t2_hold42", 128'(hold42), 128'(6));
    chk("t2_done_cyc", 128'(done_rel), 128'(506));
    chk("t2_count", 128'(count), 128'(3));

    send(8'h55); end_word(); repeat (2) tick();
    run_scan('0, 0);
    chk("t3_no_idx", 128'(hs_idx.size()), 128'(0));
    chk("t3_done_cyc", 128'(done_rel), 128'(501));
    chk("t3_count", 128'(count), 128'(0));

    send(8'h77); end_word(); repeat (3) tick();
    b_idxv = n_idxv; b_done = n_done;
    rst_n = 1'b0; tick(); tick(); rst_n = 1'b1;
    match = m3; finish = 1'b1; tick(); finish = 1'b0; match = '0;
    repeat (600) tick();
    chk("t4_no_idx", 128'(n_idxv - b_idxv), 128'(0));
    chk("t4_no_done", 128'(n_done - b_done), 128'(0));
    chk("t4_count", 128'(count), 128'(0));
    chk("t4_word", 128'(word), 128'(0));
    chk("t4_ready", 128'(cready), 128'(1));
    chk("total_starts", 128'(n_start), 128'(4));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
